match_ctrl: RTL
===============

MATCH_CTRL -- requirements
Module: match_ctrl

Interface
REQ-001 Parameter END_TICKS, default 8, clk_div rising edges held in END before auto-return to MENU.
REQ-002 Parameter SEARCH_LIMIT, default 64, maximum clk cycles per point-spawn search.
REQ-003 Parameter LFSR_SEED, default 16'hACE1, non-zero reset seed of the spawn LFSR.
REQ-004 clk  in  1  system clock; all state on posedge clk.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 clk_div  in  1  game tick, level; rising edge detected internally.
REQ-007 click_e  in  1  one-cycle start/continue pulse.
REQ-008 map  in  map_s  current map, read for tile occupancy.
REQ-009 eaten1, eaten2  in  1 each  point-eaten pulses from the collision block.
REQ-010 won, lost, draw  in  1 each  outcome pulses from the collision block.
REQ-011 mode  out  game_mode  current game mode, fed back to the collision block.
REQ-012 result  out  game_result  last match outcome (NONE/WIN/LOSE/DRAW).
REQ-013 score1, score2  out  8 each  points eaten per snake in the current match.
REQ-014 spawn_valid  out  1  one-cycle pulse: a new point is placed at spawn_x/spawn_y.
REQ-015 spawn_x, spawn_y  out  X_W, Y_W  spawn tile coordinates, valid only with spawn_valid.
REQ-016 spawn_fail  out  1  one-cycle pulse: a search hit SEARCH_LIMIT without finding a free tile.

Function
REQ-017 Main FSM states MENU, GAME, END SHALL drive mode directly from a register.
REQ-018 MENU -> GAME on click_e; on this transition score1/score2 clear to 0, result clears to NONE, and one spawn request is queued.
REQ-019 GAME -> END on any of won/lost/draw; result priority draw > lost > won when pulses coincide.
REQ-020 END -> MENU on click_e, or per REQ-031.
REQ-021 Outcome pulses outside GAME SHALL be ignored; eaten pulses outside GAME SHALL be ignored.
REQ-022 In GAME, eaten1 increments score1 and eaten2 increments score2 on the next cycle; scores saturate at 255.
REQ-023 Each eaten pulse queues one spawn request; pending counter is 2 bits and saturates at 3; simultaneous eaten1 and eaten2 add 2.
REQ-024 Spawn sub-FSM states SIDLE, SEARCH: SIDLE -> SEARCH when pending > 0 and mode == GAME.
REQ-025 In SEARCH, every cycle the LFSR advances; candidate x = LFSR low X_W bits, y = next Y_W bits; candidate accepted when x < MAP_WIDTH, y < MAP_HEIGHT and map.tiles[y][x] == EMPTY.
REQ-026 On acceptance: spawn_valid pulses for exactly one cycle with the candidate coordinates, pending decrements, sub-FSM returns to SIDLE (minimum 1 idle cycle between spawns).
REQ-027 After SEARCH_LIMIT cycles without acceptance: spawn_fail pulses for one cycle, pending decrements, return to SIDLE.
REQ-028 Leaving GAME SHALL abort any search and clear pending in the same cycle; no spawn_valid occurs in END or MENU.
REQ-029 An eaten pulse in the cycle the search completes SHALL still be counted (increment and decrement net to zero change).

Reset
REQ-030 rst_n low: mode = MENU, result = NONE, scores = 0, spawn_valid = spawn_fail = 0, spawn_x = spawn_y = 0, pending = 0, LFSR = LFSR_SEED, END tick counter = 0, clk_div edge register = 0; reset asserted mid-search discards the search.

Configuration
REQ-031 Macro MATCH_CTRL_AUTORESTART_EN defined: END -> MENU also after END_TICKS clk_div rising edges counted from END entry; undefined: END exits only on click_e and the tick counter is not built.

Structure
REQ-032 snake_pkg holds game_mode (MENU, GAME, END), game_result, MAP_WIDTH, MAP_HEIGHT, X_W, Y_W, and tile value EMPTY.
REQ-033 The 16-bit Galois LFSR (taps 16,14,13,11) is the sub-module spawn_lfsr with enable and seed inputs.

Verification
REQ-034 Reset, click_e -> mode GAME next cycle, scores 0, one spawn_valid within SEARCH_LIMIT cycles on an empty map, at a tile with EMPTY.
REQ-035 In GAME, eaten1 and eaten2 in the same cycle -> score1 = score2 = 1, two spawn_valid pulses at distinct cycles.
REQ-036 Map fully non-EMPTY, eaten1 -> spawn_fail exactly SEARCH_LIMIT cycles after search start, no spawn_valid.
REQ-037 won and draw in the same cycle -> mode END, result DRAW; later eaten1 -> score unchanged.
REQ-038 With MATCH_CTRL_AUTORESTART_EN, 8 clk_div rising edges in END -> MENU; without it, mode stays END until click_e.
REQ-039 score1 at 255 plus eaten1 -> stays 255; rst_n low mid-search -> all outputs at reset values immediately.

Source files
------------

// File: rtl/snake_pkg.sv
`default_nettype none
// ============================================================================
// snake_pkg: shared game types, map geometry and tile encoding.
// Revision: 1.0
// ============================================================================
package snake_pkg;

  localparam int unsigned MAP_WIDTH  = 20;
  localparam int unsigned MAP_HEIGHT = 15;
  localparam int unsigned X_W        = 5;
  localparam int unsigned Y_W        = 4;

  typedef logic [1:0] tile_t;
  localparam tile_t EMPTY  = 2'd0;
  localparam tile_t SNAKE1 = 2'd1;
  localparam tile_t SNAKE2 = 2'd2;
  localparam tile_t POINT  = 2'd3;

  typedef struct packed {
    tile_t [MAP_HEIGHT-1:0][MAP_WIDTH-1:0] tiles;
  } map_s;

  typedef enum logic [1:0] {
    MENU = 2'd0,
    GAME = 2'd1,
    END  = 2'd2
  } game_mode;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    WIN  = 2'd1,
    LOSE = 2'd2,
    DRAW = 2'd3
  } game_result;

  typedef enum logic [0:0] {
    SIDLE  = 1'b0,
    SEARCH = 1'b1
  } spawn_state_e;

  // Candidates outside the playfield are rejected before the tile lookup matters.
  function automatic logic tile_free(input map_s m, input logic [X_W-1:0] x,
                                     input logic [Y_W-1:0] y);
    return (32'(x) < MAP_WIDTH) && (32'(y) < MAP_HEIGHT) && (m.tiles[y][x] == EMPTY);
  endfunction

endpackage
`default_nettype wire

// File: rtl/spawn_lfsr.sv
`default_nettype none
// ============================================================================
// spawn_lfsr: 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1) with enable and seed.
// Revision: 1.0
// ============================================================================
module spawn_lfsr (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_i,
  input  logic [15:0] seed_i,
  output logic [15:0] state_o
);

  logic [15:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (en_i) begin
      state_d = {1'b0, state_q[15:1]} ^ (state_q[0] ? 16'hB400 : 16'h0000);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= seed_i;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule
`default_nettype wire

// File: rtl/match_ctrl.sv
`default_nettype none
// ============================================================================
// match_ctrl: game mode / result / score controller with random point spawner.
// Build option: MATCH_CTRL_AUTORESTART_EN (END returns to MENU after END_TICKS).
// Revision: 1.0
// ============================================================================
module match_ctrl
  import snake_pkg::*;
#(
  parameter int unsigned END_TICKS    = 8,
  parameter int unsigned SEARCH_LIMIT = 64,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clk_div,
  input  logic           click_e,
  input  map_s           map,
  input  logic           eaten1,
  input  logic           eaten2,
  input  logic           won,
  input  logic           lost,
  input  logic           draw,
  output game_mode       mode,
  output game_result     result,
  output logic [7:0]     score1,
  output logic [7:0]     score2,
  output logic           spawn_valid,
  output logic [X_W-1:0] spawn_x,
  output logic [Y_W-1:0] spawn_y,
  output logic           spawn_fail
);

  localparam int unsigned c_SCNT_W = (SEARCH_LIMIT > 1) ? $clog2(SEARCH_LIMIT) : 1;

  game_mode            mode_q, mode_d;
  game_result          result_q, result_d;
  logic [7:0]          score1_q, score1_d;
  logic [7:0]          score2_q, score2_d;
  logic [1:0]          pend_q, pend_d;
  spawn_state_e        sstate_q, sstate_d;
  logic [c_SCNT_W-1:0] scnt_q, scnt_d;
  logic                sv_q, sv_d;
  logic                sf_q, sf_d;
  logic [X_W-1:0]      sx_q, sx_d;
  logic [Y_W-1:0]      sy_q, sy_d;

  logic [15:0]         w_lfsr;
  logic                w_lfsr_en;
  logic                w_in_game;
  logic                w_outcome;
  logic                w_leave;
  logic                w_start;
  logic                w_done;
  logic                w_cand_ok;
  logic                w_auto_exit;
  logic                w_unused_ok;
  logic [X_W-1:0]      w_cand_x;
  logic [Y_W-1:0]      w_cand_y;
  logic [1:0]          w_inc;
  logic [2:0]          w_sum;

  spawn_lfsr u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (w_lfsr_en),
    .seed_i  (LFSR_SEED),
    .state_o (w_lfsr)
  );

  assign w_cand_x  = w_lfsr[X_W-1:0];
  assign w_cand_y  = w_lfsr[X_W+Y_W-1:X_W];
  assign w_cand_ok = tile_free(map, w_cand_x, w_cand_y);

  assign w_in_game = (mode_q == GAME);
  assign w_outcome = won | lost | draw;
  assign w_leave   = w_in_game & w_outcome;

`ifdef MATCH_CTRL_AUTORESTART_EN
  localparam int unsigned c_TICK_W = $clog2(END_TICKS + 1);

  logic                div_q;
  logic                w_div_rise;
  logic [c_TICK_W-1:0] tick_q, tick_d;

  assign w_div_rise = clk_div & ~div_q;

  // Counter stays cleared outside END so every END visit starts from zero.
  always_comb begin
    tick_d      = tick_q;
    w_auto_exit = 1'b0;
    if (mode_q != END) begin
      tick_d = '0;
    end else if (w_div_rise) begin
      if (tick_q == c_TICK_W'(END_TICKS - 1)) begin
        w_auto_exit = 1'b1;
        tick_d      = '0;
      end else begin
        tick_d = tick_q + c_TICK_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= 1'b0;
      tick_q <= '0;
    end else begin
      div_q  <= clk_div;
      tick_q <= tick_d;
    end
  end

  assign w_unused_ok = ^w_lfsr[15:X_W+Y_W];
`else
  assign w_auto_exit = 1'b0;
  assign w_unused_ok = ^{w_lfsr[15:X_W+Y_W], clk_div, (END_TICKS != 0)};
`endif

  always_comb begin
    mode_d   = mode_q;
    result_d = result_q;
    score1_d = score1_q;
    score2_d = score2_q;
    w_start  = 1'b0;
    case (mode_q)
      MENU: begin
        if (click_e) begin
          mode_d   = GAME;
          result_d = NONE;
          score1_d = 8'd0;
          score2_d = 8'd0;
          w_start  = 1'b1;
        end
      end
      GAME: begin
        if (eaten1 && (score1_q != 8'hFF)) score1_d = score1_q + 8'd1;
        if (eaten2 && (score2_q != 8'hFF)) score2_d = score2_q + 8'd1;
        if (w_outcome) begin
          mode_d = END;
          if (draw)      result_d = DRAW;
          else if (lost) result_d = LOSE;
          else           result_d = WIN;
        end
      end
      END: begin
        if (click_e || w_auto_exit) mode_d = MENU;
      end
      default: mode_d = MENU;
    endcase
  end

  // A search in flight when GAME is left is dropped without any pulse.
  always_comb begin
    sstate_d  = sstate_q;
    scnt_d    = scnt_q;
    sv_d      = 1'b0;
    sf_d      = 1'b0;
    sx_d      = sx_q;
    sy_d      = sy_q;
    w_lfsr_en = 1'b0;
    w_done    = 1'b0;
    case (sstate_q)
      SIDLE: begin
        if (w_in_game && !w_leave && (pend_q != 2'd0)) begin
          sstate_d = SEARCH;
          scnt_d   = '0;
        end
      end
      SEARCH: begin
        w_lfsr_en = 1'b1;
        if (!w_in_game || w_leave) begin
          sstate_d = SIDLE;
        end else if (w_cand_ok) begin
          sv_d     = 1'b1;
          sx_d     = w_cand_x;
          sy_d     = w_cand_y;
          w_done   = 1'b1;
          sstate_d = SIDLE;
        end else if (scnt_q == c_SCNT_W'(SEARCH_LIMIT - 1)) begin
          sf_d     = 1'b1;
          w_done   = 1'b1;
          sstate_d = SIDLE;
        end else begin
          scnt_d = scnt_q + c_SCNT_W'(1);
        end
      end
      default: sstate_d = SIDLE;
    endcase
  end

  // Requests and a completion in the same cycle net out before saturation.
  always_comb begin
    w_inc = 2'd0;
    if (w_in_game) w_inc = {1'b0, eaten1} + {1'b0, eaten2};
    w_sum = {1'b0, pend_q} + {1'b0, w_inc} - {2'b00, w_done};
    if (w_start) begin
      pend_d = 2'd1;
    end else if (!w_in_game || w_leave) begin
      pend_d = 2'd0;
    end else if (w_sum > 3'd3) begin
      pend_d = 2'd3;
    end else begin
      pend_d = w_sum[1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= MENU;
      result_q <= NONE;
      score1_q <= 8'd0;
      score2_q <= 8'd0;
      pend_q   <= 2'd0;
      sstate_q <= SIDLE;
      scnt_q   <= '0;
      sv_q     <= 1'b0;
      sf_q     <= 1'b0;
      sx_q     <= '0;
      sy_q     <= '0;
    end else begin
      mode_q   <= mode_d;
      result_q <= result_d;
      score1_q <= score1_d;
      score2_q <= score2_d;
      pend_q   <= pend_d;
      sstate_q <= sstate_d;
      scnt_q   <= scnt_d;
      sv_q     <= sv_d;
      sf_q     <= sf_d;
      sx_q     <= sx_d;
      sy_q     <= sy_d;
    end
  end

  assign mode        = mode_q;
  assign result      = result_q;
  assign score1      = score1_q;
  assign score2      = score2_q;
  assign spawn_valid = sv_q;
  assign spawn_fail  = sf_q;
  assign spawn_x     = sx_q;
  assign spawn_y     = sy_q;

endmodule
`default_nettype wire
